// File: rtl/loader_pkg.sv
// Shared types and sizing helpers for the serial operand loader.
package loader_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } loader_state_e;

    function automatic int frame_len(input int width);
        return 2 * width;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/operand_serial_loader.sv
// Assembles operands A and B from a qualified serial stream and holds the
// registered pair under a valid/ready handshake until the AND stage takes it.
module operand_serial_loader
    import loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic                sdi,
    input  logic                sdi_vld,
    output logic [WIDTH-1:0]    a_out,
    output logic [WIDTH-1:0]    b_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [7:0]          frame_cnt,
    output logic                overrun,
    output loader_state_e       dbg_state
);

    // Handshake: a pair transfers on the rising edge where out_valid, out_ready
    // and ena are all high; out_valid never drops before that edge.
    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    loader_state_e     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FLEN-1:0]   shreg_q, shreg_d;
    logic [FLEN-1:0]   shifted;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        a_d     = a_q;
        b_d     = b_q;
        fcnt_d  = fcnt_q;
        ovr_d   = ovr_q;
        // LSB-first shifts right so the first bit received lands at bit 0.
        shifted = MSB_FIRST ? {shreg_q[FLEN-2:0], sdi} : {sdi, shreg_q[FLEN-1:1]};

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        cnt_d = '0;
                        ovr_d = 1'b1;
                    end else if (sdi_vld) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                            a_d     = MSB_FIRST ? shifted[FLEN-1:WIDTH] : shifted[WIDTH-1:0];
                            b_d     = MSB_FIRST ? shifted[WIDTH-1:0]    : shifted[FLEN-1:WIDTH];
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        fcnt_d  = fcnt_q + 8'd1;
                        state_d = start ? SHIFT : IDLE;
                        cnt_d   = '0;
                    end else if (start) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == SHIFT);
    assign frame_cnt = fcnt_q;
    assign overrun   = ovr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_serial_loader.sv
// Directed plus randomized bench for operand_serial_loader, run on an
// MSB-first and an LSB-first instance fed from the same stimulus.
module tb_operand_serial_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic start = 1'b0;
    logic sdi = 1'b0;
    logic sdi_vld = 1'b0;
    logic out_ready = 1'b0;

    logic [7:0] a_m, b_m, fc_m, a_l, b_l, fc_l;
    logic       v_m, busy_m, ovr_m, v_l, busy_l, ovr_l;
    loader_state_e st_m, st_l;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int fc_exp  = 0;

    always #5 clk = ~clk;

    operand_serial_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sdi(sdi),
        .sdi_vld(sdi_vld), .a_out(a_m), .b_out(b_m), .out_valid(v_m),
        .out_ready(out_ready), .busy(busy_m), .frame_cnt(fc_m),
        .overrun(ovr_m), .dbg_state(st_m)
    );

    operand_serial_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sdi(sdi),
        .sdi_vld(sdi_vld), .a_out(a_l), .b_out(b_l), .out_valid(v_l),
        .out_ready(out_ready), .busy(busy_l), .frame_cnt(fc_l),
        .overrun(ovr_l), .dbg_state(st_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a"},     32'(a_m),    32'h0);
        chk({tag, "_b"},     32'(b_m),    32'h0);
        chk({tag, "_valid"}, 32'(v_m),    32'h0);
        chk({tag, "_busy"},  32'(busy_m), 32'h0);
        chk({tag, "_fcnt"},  32'(fc_m),   32'h0);
        chk({tag, "_ovr"},   32'(ovr_m),  32'h0);
        chk({tag, "_state"}, 32'(st_m),   32'(IDLE));
        chk({tag, "_a_lsb"}, 32'(a_l),    32'h0);
        chk({tag, "_b_lsb"}, 32'(b_l),    32'h0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        check_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        fc_exp = 0;
        tick();
    endtask

    // Start pulse; sdi_vld is driven high to show it is ignored here.
    task automatic pulse_start();
        start   = 1'b1;
        sdi_vld = 1'b1;
        sdi     = 1'($urandom_range(0, 1));
        tick();
        start   = 1'b0;
        sdi_vld = 1'b0;
        chk("start_busy", 32'(busy_m), 32'h1);
    endtask

    // Sends the first nbits of stream, stream[15] first. Optional random gaps
    // and a 4-cycle ena-low window before bit ena_off_at.
    task automatic send_bits(input logic [15:0] stream, input int nbits,
                             input int max_gap, input int ena_off_at);
        for (int i = 0; i < nbits; i++) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin
                sdi_vld = 1'b0;
                sdi     = 1'($urandom_range(0, 1));
                tick();
            end
            if (i == ena_off_at) begin
                ena     = 1'b0;
                sdi_vld = 1'b1;
                repeat (4) begin
                    sdi = 1'($urandom_range(0, 1));
                    tick();
                end
                chk("ena_off_busy", 32'(busy_m), 32'h1);
                ena = 1'b1;
            end
            if (i == 15) chk("pre_valid", 32'(v_m), 32'h0);
            sdi     = stream[15-i];
            sdi_vld = 1'b1;
            tick();
        end
        sdi_vld = 1'b0;
    endtask

    // Reference: bit list in arrival order, interpreted per bit order.
    task automatic check_frame(input logic [15:0] stream);
        bit bits[$];
        int am, bm, al, bl;
        for (int i = 0; i < 16; i++) bits.push_back(stream[15-i]);
        am = 0; bm = 0; al = 0; bl = 0;
        for (int i = 0; i < 8; i++) begin
            am = am * 2 + int'(bits[i]);
            bm = bm * 2 + int'(bits[8+i]);
            al = al + (int'(bits[i]) << i);
            bl = bl + (int'(bits[8+i]) << i);
        end
        chk("valid",     32'(v_m),    32'h1);
        chk("busy_hold", 32'(busy_m), 32'h0);
        chk("a_msb",     32'(a_m),    32'(am));
        chk("b_msb",     32'(b_m),    32'(bm));
        chk("valid_lsb", 32'(v_l),    32'h1);
        chk("a_lsb",     32'(a_l),    32'(al));
        chk("b_lsb",     32'(b_l),    32'(bl));
    endtask

    task automatic handshake(input logic also_start);
        out_ready = 1'b1;
        start     = also_start;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        fc_exp    = (fc_exp + 1) % 256;
        chk("hs_valid", 32'(v_m),  32'h0);
        chk("hs_fcnt",  32'(fc_m), 32'(fc_exp));
        chk("hs_fcnt_lsb", 32'(fc_l), 32'(fc_exp));
        chk("hs_busy",  32'(busy_m), 32'(also_start));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s;

        // Reset state and a first MSB-first frame A=0xA5 B=0x3C.
        apply_reset();
        pulse_start();
        send_bits(16'hA53C, 16, 0, -1);
        check_frame(16'hA53C);
        chk("and_out", 32'(a_m & b_m), 32'h24);
        chk("no_ovr", 32'(ovr_m), 32'h0);
        handshake(1'b0);

        // Same frame, consumer stalls 10 cycles with a stray start mid-hold.
        pulse_start();
        send_bits(16'hA53C, 16, 0, -1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            chk("stall_valid", 32'(v_m), 32'h1);
            chk("stall_a", 32'(a_m), 32'hA5);
            chk("stall_b", 32'(b_m), 32'h3C);
        end
        start = 1'b0;
        chk("stall_ovr",  32'(ovr_m), 32'h1);
        chk("stall_fcnt", 32'(fc_m),  32'h1);
        handshake(1'b0);

        // Restart after 5 bits, with a qualified bit on the restart cycle.
        apply_reset();
        pulse_start();
        send_bits(16'h5555, 5, 0, -1);
        start = 1'b1; sdi_vld = 1'b1; sdi = 1'b1;
        tick();
        start = 1'b0; sdi_vld = 1'b0;
        chk("restart_ovr",  32'(ovr_m),  32'h1);
        chk("restart_busy", 32'(busy_m), 32'h1);
        send_bits(16'hFF0F, 16, 0, -1);
        check_frame(16'hFF0F);

        // Async reset after 9 bits of a back-to-back frame.
        handshake(1'b1);
        send_bits(16'hC3C3, 9, 1, -1);
        apply_reset();
        pulse_start();
        send_bits(16'h8118, 16, 2, -1);
        check_frame(16'h8118);
        chk("post_rst_ovr", 32'(ovr_m), 32'h0);
        handshake(1'b0);

        // 256 back-to-back frames; first one is the LSB-first pattern.
        apply_reset();
        pulse_start();
        for (int f = 0; f < 256; f++) begin
            s = (f == 0) ? 16'h80FF : 16'($urandom);
            send_bits(s, 16, (f % 4 == 0) ? 0 : 2, -1);
            check_frame(s);
            handshake(f < 255);
        end
        chk("wrap_fcnt", 32'(fc_m), 32'h0);
        chk("wrap_ovr",  32'(ovr_m), 32'h0);

        // ena low for 4 cycles mid-frame with sdi_vld high.
        pulse_start();
        send_bits(16'h5AC3, 16, 0, 6);
        check_frame(16'h5AC3);
        chk("ena_fcnt", 32'(fc_m), 32'h0);
        handshake(1'b0);
        chk("end_state", 32'(st_m), 32'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_serial_loader.md
# operand_serial_loader

Upstream stage of the 8-bit bitwise-AND datapath: assembles operands A and B from a qualified serial bit stream and presents them, registered and held stable, to the AND stage over a valid/ready handshake. It replaces direct parallel pin drive when pins are scarce and guarantees the AND stage never sees a half-loaded operand pair. Counts delivered frames and flags protocol violations.

## Interface
- WIDTH, 8, operand width in bits; frame is 2*WIDTH bits
- MSB_FIRST, 1, 1: each operand sent MSB first; 0: LSB first
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; 0 freezes all state, handshake not accepted
- start  in  1  single-cycle pulse, begins a frame
- sdi  in  1  serial data bit
- sdi_vld  in  1  sdi qualifier; one bit accepted per cycle high
- a_out  out  WIDTH  operand A to AND stage
- b_out  out  WIDTH  operand B to AND stage
- out_valid  out  1  a_out/b_out hold a complete frame
- out_ready  in  1  AND stage consumes pair
- busy  out  1  high while in SHIFT
- frame_cnt  out  8  delivered frames, wraps 255 -> 0
- overrun  out  1  sticky protocol-violation flag

## Operation
- Reset values: a_out=0, b_out=0, out_valid=0, busy=0, frame_cnt=0, overrun=0, state IDLE, bit counter 0.
- FSM states IDLE, SHIFT, HOLD; all transitions only when ena=1.
- IDLE: start -> SHIFT, bit counter cleared; sdi_vld ignored (including on the start cycle).
- SHIFT: each sdi_vld shifts sdi into a 2*WIDTH shift register, counter +1; first WIDTH bits form A, next WIDTH form B, in MSB_FIRST order. On the accepted bit with counter=2*WIDTH-1: load a_out/b_out, out_valid=1, -> HOLD.
- start in SHIFT: frame restarts (counter=0, partial data discarded), overrun set; the sdi_vld bit on that cycle is discarded.
- HOLD: out_valid=1, a_out/b_out stable. out_valid&&out_ready -> frame_cnt+1, out_valid=0, -> IDLE; if start in same cycle, -> SHIFT directly, no overrun.
- start in HOLD without out_ready: ignored, overrun set. sdi_vld in HOLD ignored.
- a_out/b_out keep last frame after handshake; change only on frame completion.
- overrun cleared only by reset.
- Reset asserted mid-frame: immediate return to reset values; partial frame lost.

## Timing
- start at cycle N, sdi_vld continuous from N+1: last bit at N+2*WIDTH, out_valid high at N+2*WIDTH+1 (17 cycles for WIDTH=8).
- Gaps in sdi_vld stretch latency one cycle per gap cycle; no timeout.
- Handshake completes on the edge where out_valid&&out_ready&&ena; out_valid low the next cycle.
- Back-to-back: start in the handshake cycle gives the next out_valid at 2*WIDTH+1 cycles later.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package loader_pkg: state enum typedef (IDLE, SHIFT, HOLD), frame-length constant 2*WIDTH, counter width via $clog2.
- Single module; no sub-module. Shift register, bit counter, FSM and frame counter inline.

## Test plan
- Reset, start, 16 bits A=0xA5 then B=0x3C MSB first -> out_valid at start+17, a_out=0xA5, b_out=0x3C, downstream AND yields 0x24, frame_cnt=1.
- Same frame, out_ready held low 10 cycles, extra start during hold -> outputs stable, overrun=1, frame_cnt increments only when out_ready rises.
- start after 5 bits, then full frame A=0xFF B=0x0F -> overrun=1, a_out=0xFF, b_out=0x0F.
- rst_n low after 9 bits -> all outputs 0 immediately; subsequent frame A=0x81 B=0x18 loads correctly.
- MSB_FIRST=0, bits 1,0,0,0,0,0,0,0 then eight 1s -> a_out=0x01, b_out=0xFF; 256 back-to-back frames -> frame_cnt wraps to 0.
- ena low for 4 cycles mid-frame with sdi_vld high -> no bits accepted, valid delayed by 4 cycles, data intact.
